// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder (PIPE_ADDER_SAT_EN adds sat)
interface pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
`ifdef PIPE_ADDER_SAT_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, sub,
`ifdef PIPE_ADDER_SAT_EN
      output sat,
`endif
      output out_ready,
      input  in_ready, out_valid, s, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub,
`ifdef PIPE_ADDER_SAT_EN
      input  sat,
`endif
      input  out_ready,
      output in_ready, out_valid, s, c_out, ovf
   );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined chunked ripple-carry add/subtract with valid/ready (PIPE_ADDER_SAT_EN enables saturation)
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic        clk,
   input  logic        rst,
   pipe_adder_if.slave bus
);
   localparam int SDIV  = (STAGES >= 1) ? STAGES : 1;
   localparam int CHUNK = WIDTH / SDIV;

   if (STAGES < 1 || (WIDTH % SDIV) != 0) begin : g_bad_cfg
      $error("pipe_adder: STAGES must be >= 1 and divide WIDTH evenly");
   end

`ifdef PIPE_ADDER_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   // Per-stage registers: stage k holds result chunks 0..k and the operands
   // still needed by later stages (full width kept; unread bits fall away).
   logic             vld_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] r_q   [STAGES];
   logic             c_q   [STAGES];
`ifdef PIPE_ADDER_SAT_EN
   logic             sat_q [STAGES];
`endif
   logic             ovf_q;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // The whole pipeline moves as one: it shifts unless a result is stuck at the output
   assign advance      = !vld_q[STAGES-1] | bus.out_ready;
   assign bus.in_ready = advance;

   // Subtraction is a + ~b + 1; the external carry-in is ignored then
   assign b_eff   = bus.sub ? ~bus.b : bus.b;
   assign cin_eff = bus.sub ? 1'b1 : bus.c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             v_i;
      logic [WIDTH-1:0] a_i;
      logic [WIDTH-1:0] b_i;
      logic [WIDTH-1:0] r_i;
      logic             c_i;
      logic [WIDTH-1:0] r_n;
      logic [WIDTH-1:0] r_d;
      logic [CHUNK:0]   sum;
`ifdef PIPE_ADDER_SAT_EN
      logic             sat_i;
`endif

      if (k == 0) begin : g_src
         assign v_i = bus.in_valid;
         assign a_i = bus.a;
         assign b_i = b_eff;
         assign r_i = '0;
         assign c_i = cin_eff;
`ifdef PIPE_ADDER_SAT_EN
         assign sat_i = bus.sat;
`endif
      end else begin : g_src
         assign v_i = vld_q[k-1];
         assign a_i = a_q[k-1];
         assign b_i = b_q[k-1];
         assign r_i = r_q[k-1];
         assign c_i = c_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
         assign sat_i = sat_q[k-1];
`endif
      end

      assign sum = {1'b0, a_i[k*CHUNK +: CHUNK]}
                 + {1'b0, b_i[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_i};

      // Splice this stage's chunk over the lower results carried in from earlier stages
      always_comb begin
         r_n                   = r_i;
         r_n[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end

      if (k == STAGES-1) begin : g_tail
         logic ovf_n;

         // Same-sign operands producing an opposite-sign result overflowed
         assign ovf_n = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (r_n[WIDTH-1] != a_i[WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
         assign r_d = (sat_i && ovf_n) ? (a_i[WIDTH-1] ? SAT_MIN : SAT_MAX) : r_n;
`else
         assign r_d = r_n;
`endif

         // Overflow flag is registered together with the top chunk
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= ovf_n;
            end
         end
      end else begin : g_tail
         assign r_d = r_n;
      end

      // Stage register: load from the previous stage on advance, hold otherwise
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q[k] <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            r_q[k]   <= '0;
            c_q[k]   <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
            sat_q[k] <= 1'b0;
`endif
         end else if (advance) begin
            vld_q[k] <= v_i;
            a_q[k]   <= a_i;
            b_q[k]   <= b_i;
            r_q[k]   <= r_d;
            c_q[k]   <= sum[CHUNK];
`ifdef PIPE_ADDER_SAT_EN
            sat_q[k] <= sat_i;
`endif
         end
      end
   end

   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.s         = r_q[STAGES-1];
   assign bus.c_out     = c_q[STAGES-1];
   assign bus.ovf       = ovf_q;
endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry add/subtract unit; next generation of the team's 8-bit combinational ripple-carry adder.
- WIDTH-bit operands split into STAGES equal chunks; each chunk is added in its own register stage, and the carry is registered between stages.
- Valid/ready handshake on both sides lets it sit directly in the datapath between a producer and a stalling consumer.

Parameters:
- WIDTH, 32, operand and result width in bits
- STAGES, 4, pipeline depth and chunk count; must satisfy STAGES>=1 and WIDTH%STAGES==0, otherwise elaboration fails
- CHUNK, WIDTH/STAGES, derived localparam, bits added per stage

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in; ignored when sub=1
- sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- c_out  output  1  carry-out of the MSB (for sub, 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset is synchronous and active-high. With rst=1 at a clk edge, every stage valid bit clears and out_valid, s, c_out and ovf become 0. All stage data registers also clear.
- in_ready = advance = !out_valid | out_ready; this is combinational. in_ready is 1 after reset.
- Pipeline control:
  - When advance=1, every stage shifts by one.
  - When advance=0, the whole pipeline holds.
  - Bubbles are not collapsed.
- A transfer is accepted when in_valid & in_ready. When in_ready=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Operand preparation at stage 0:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? 1 : c_in
- Stage k (0..STAGES-1):
  - Computes chunk k: {carry_k+1, s_k} = a_k + b_eff_k + carry_k, where carry_0 = cin_eff.
  - Registers s_k and carry_k+1.
  - Upper operand chunks k+1.. are skewed forward in registers.
  - Lower result chunks 0..k-1 are delay-balanced forward.
- Outputs:
  - s is the concatenation of all chunk results.
  - c_out is the carry from the top chunk.
  - ovf = (a[W-1] == b_eff[W-1]) & (s[W-1] != a[W-1]). The two MSBs are carried down the pipeline.
- Latency is exactly STAGES cycles from acceptance to out_valid when there is no stall; throughput is 1 result per cycle.
- STAGES=1 gives a single registered adder with latency 1.
- While out_valid & !out_ready, the outputs s, c_out and ovf are held stable.
- Results leave in the order accepted, with no loss or duplication.
- Reset mid-operation discards all in-flight transactions. out_valid=0 on the cycle after the reset edge.
- Arithmetic wraps modulo 2^WIDTH; c_out and ovf report the out-of-range cases.
- Simultaneous accept and emit in one cycle is legal and required at full throughput.

Optional Feature:
- Macro: PIPE_ADDER_SAT_EN
- Defined:
  - Adds input port sat (1 bit), captured with the operands.
  - If sat=1 and ovf=1, s is clamped to the signed extreme: 0x7F..F when a[W-1]=0, else 0x80..0.
  - ovf is still reported as 1; c_out is unchanged.
  - Clamping happens in the last stage, so latency is unchanged.
- Not defined: no sat port; results always wrap.

Test Plan:
- Full carry ripple (WIDTH=32, STAGES=4): a=0xFFFFFFFF, b=0, c_in=1, sub=0 -> exactly 4 cycles later out_valid=1, s=0x00000000, c_out=1, ovf=0.
- Subtract with borrow: a=5, b=7, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0. Then a=7, b=5, sub=1 -> s=2, c_out=1.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, ovf=1, c_out=0. With PIPE_ADDER_SAT_EN and sat=1 -> s=0x7FFFFFFF, ovf=1.
- Backpressure: back-to-back stream a=i, b=i, i=1..6; out_ready low for 3 cycles mid-stream -> in_ready low in the same cycles, outputs stable while stalled, results 2,4,6,8,10,12 in order with no duplicates.
- Reset mid-flight: 3 transactions in flight, rst=1 for one cycle -> out_valid=0 and s=0 from the next cycle; none of the 3 results ever appears; the next accepted op completes with normal 4-cycle latency.
- Parameter sweep: WIDTH=8 with STAGES=1,2,8 against a random-operand scoreboard (1000 ops, random in_valid/out_ready) -> all s, c_out and ovf match the reference model.
